// File: rtl/divider_pkg.sv
// Shared constants, control decode and helpers for the RV64M iterative divider.
package divider_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned OPC_W = 9;
  localparam int unsigned WORD  = 32;

  localparam logic [OPC_W-1:0] INST_DIV   = 9'h0a0;
  localparam logic [OPC_W-1:0] INST_DIVU  = 9'h0a1;
  localparam logic [OPC_W-1:0] INST_REM   = 9'h0a2;
  localparam logic [OPC_W-1:0] INST_REMU  = 9'h0a3;
  localparam logic [OPC_W-1:0] INST_DIVW  = 9'h0a4;
  localparam logic [OPC_W-1:0] INST_DIVUW = 9'h0a5;
  localparam logic [OPC_W-1:0] INST_REMW  = 9'h0a6;
  localparam logic [OPC_W-1:0] INST_REMUW = 9'h0a7;

  typedef struct packed {
    logic valid;
    logic signed_op;
    logic word;
    logic rem;
  } div_ctrl_t;

  // Opcode to operation flags; valid is low for anything outside the divide group.
  function automatic div_ctrl_t decode_div(input logic [OPC_W-1:0] opc);
    div_ctrl_t c;
    c = '0;
    case (opc)
      INST_DIV:   c = '{valid: 1'b1, signed_op: 1'b1, word: 1'b0, rem: 1'b0};
      INST_DIVU:  c = '{valid: 1'b1, signed_op: 1'b0, word: 1'b0, rem: 1'b0};
      INST_REM:   c = '{valid: 1'b1, signed_op: 1'b1, word: 1'b0, rem: 1'b1};
      INST_REMU:  c = '{valid: 1'b1, signed_op: 1'b0, word: 1'b0, rem: 1'b1};
      INST_DIVW:  c = '{valid: 1'b1, signed_op: 1'b1, word: 1'b1, rem: 1'b0};
      INST_DIVUW: c = '{valid: 1'b1, signed_op: 1'b0, word: 1'b1, rem: 1'b0};
      INST_REMW:  c = '{valid: 1'b1, signed_op: 1'b1, word: 1'b1, rem: 1'b1};
      INST_REMUW: c = '{valid: 1'b1, signed_op: 1'b0, word: 1'b1, rem: 1'b1};
      default:    c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] x);
    return {{(XLEN-WORD){x[WORD-1]}}, x[WORD-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] zext_word(input logic [XLEN-1:0] x);
    return {{(XLEN-WORD){1'b0}}, x[WORD-1:0]};
  endfunction

endpackage

// File: rtl/div_operand_prep.sv
// Operand preparation: W-form extension, absolute values and result sign flags.
module div_operand_prep
  import divider_pkg::*;
(
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            word,
  input  logic            signed_op,
  output logic [XLEN-1:0] ext1,
  output logic [XLEN-1:0] abs1,
  output logic [XLEN-1:0] abs2,
  output logic            q_neg,
  output logic            r_neg
);

  logic [XLEN-1:0] ext2;
  logic            s1;
  logic            s2;

  always_comb begin
    ext1 = op1;
    ext2 = op2;
    if (word) begin
      ext1 = signed_op ? sext_word(op1) : zext_word(op1);
      ext2 = signed_op ? sext_word(op2) : zext_word(op2);
    end
    s1    = signed_op & ext1[XLEN-1];
    s2    = signed_op & ext2[XLEN-1];
    // -2^63 maps onto itself, which the unsigned datapath reads as 2^63.
    abs1  = s1 ? -ext1 : ext1;
    abs2  = s2 ? -ext2 : ext2;
    q_neg = s1 ^ s2;
    r_neg = s1;
  end

endmodule

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
module divider
  import divider_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            div_start,
  input  logic            div_flush,
  input  logic [OPC_W-1:0] inst_opcode,
  input  logic [XLEN-1:0] div_op1,
  input  logic [XLEN-1:0] div_op2,
  output logic            div_busy,
  output logic [XLEN-1:0] div_result,
  output logic            div_finish
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  dvsr;
  logic             q_neg;
  logic             r_neg;
  logic             word;
  logic             rem_sel;

  div_ctrl_t        ctrl;
  logic [XLEN-1:0]  prep_ext1;
  logic [XLEN-1:0]  prep_abs1;
  logic [XLEN-1:0]  prep_abs2;
  logic             prep_q_neg;
  logic             prep_r_neg;

  logic [XLEN-1:0]  partial;
  logic [XLEN:0]    diff;
  logic [XLEN-1:0]  next_rem;
  logic [XLEN-1:0]  next_quo;
  logic [XLEN-1:0]  fixed;
  logic [XLEN-1:0]  calc_res;
  logic [XLEN-1:0]  zero_res;

  assign ctrl = decode_div(inst_opcode);

  div_operand_prep u_prep (
    .op1       (div_op1),
    .op2       (div_op2),
    .word      (ctrl.word),
    .signed_op (ctrl.signed_op),
    .ext1      (prep_ext1),
    .abs1      (prep_abs1),
    .abs2      (prep_abs2),
    .q_neg     (prep_q_neg),
    .r_neg     (prep_r_neg)
  );

  // One restoring step plus the sign-fixed result of that step, used on the last iteration.
  always_comb begin
    partial  = {rem[XLEN-2:0], quo[XLEN-1]};
    diff     = {1'b0, partial} - {1'b0, dvsr};
    next_rem = diff[XLEN] ? partial : diff[XLEN-1:0];
    next_quo = {quo[XLEN-2:0], ~diff[XLEN]};
    if (rem_sel) begin
      fixed = r_neg ? -next_rem : next_rem;
    end else begin
      fixed = q_neg ? -next_quo : next_quo;
    end
    calc_res = word ? sext_word(fixed) : fixed;
    zero_res = ctrl.rem ? prep_ext1 : '1;
    if (ctrl.word) begin
      zero_res = sext_word(zero_res);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      dvsr       <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      word       <= 1'b0;
      rem_sel    <= 1'b0;
      div_busy   <= 1'b0;
      div_finish <= 1'b0;
      div_result <= '0;
    end else if (div_flush) begin
      state      <= IDLE;
      div_busy   <= 1'b0;
      div_finish <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_finish <= 1'b0;
          if (div_start && ctrl.valid) begin
            q_neg   <= prep_q_neg;
            r_neg   <= prep_r_neg;
            word    <= ctrl.word;
            rem_sel <= ctrl.rem;
            dvsr    <= prep_abs2;
            quo     <= prep_abs1;
            rem     <= '0;
            cnt     <= '0;
            if (prep_abs2 == '0) begin
              state      <= DONE;
              div_finish <= 1'b1;
              div_result <= zero_res;
            end else begin
              state    <= CALC;
              div_busy <= 1'b1;
            end
          end
        end
        CALC: begin
          rem <= next_rem;
          quo <= next_quo;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN - 1)) begin
            state      <= DONE;
            div_busy   <= 1'b0;
            div_finish <= 1'b1;
            div_result <= calc_res;
          end
        end
        DONE: begin
          state      <= IDLE;
          div_finish <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the iterative divider: results, latency, flush and reset.
module tb_divider;
  import divider_pkg::*;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic        div_flush;
  logic [8:0]  inst_opcode;
  logic [63:0] div_op1;
  logic [63:0] div_op2;
  logic        div_busy;
  logic [63:0] div_result;
  logic        div_finish;

  int tests;
  int fails;

  divider dut (
    .clk         (clk),
    .rst         (rst),
    .div_start   (div_start),
    .div_flush   (div_flush),
    .inst_opcode (inst_opcode),
    .div_op1     (div_op1),
    .div_op2     (div_op2),
    .div_busy    (div_busy),
    .div_result  (div_result),
    .div_finish  (div_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start in cycle 0, scramble operands afterwards, expect finish in cycle exp_lat.
  task automatic run_op(input string tag, input logic [8:0] opc, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_r, input int exp_lat);
    int lat;
    lat = -1;
    @(negedge clk);
    div_start   = 1'b1;
    inst_opcode = opc;
    div_op1     = a;
    div_op2     = b;
    for (int c = 1; c <= 100 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, " busy_c1"}, 64'(div_busy), 64'(exp_lat > 1));
        div_start = 1'b0;
        div_op1   = 64'h0123_4567_89ab_cdef;
        div_op2   = 64'h3;
      end
      if (div_finish) lat = c;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, div_result, exp_r);
    @(negedge clk);
    check({tag, " finish_pulse"}, 64'(div_finish), 64'd0);
    check({tag, " result_hold"}, div_result, exp_r);
  endtask

  initial begin
    int lat;
    int nfin;
    tests       = 0;
    fails       = 0;
    rst         = 1'b0;
    div_start   = 1'b0;
    div_flush   = 1'b0;
    inst_opcode = '0;
    div_op1     = '0;
    div_op2     = '0;

    repeat (2) @(negedge clk);
    check("reset busy", 64'(div_busy), 64'd0);
    check("reset finish", 64'(div_finish), 64'd0);
    check("reset result", div_result, 64'd0);
    rst = 1'b1;

    run_op("div 20/-3",   INST_DIV,  64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 65);
    run_op("rem 20/-3",   INST_REM,  64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 65);
    run_op("rem -20/3",   INST_REM,  64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("divu /0",     INST_DIVU, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu /0",     INST_REMU, 64'h1234, 64'd0, 64'h1234, 1);
    run_op("divw /0",     INST_DIVW, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remw /0",     INST_REMW, 64'h1234_5678_FFFF_FFF9, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFF9, 1);
    run_op("div ovf",     INST_DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 65);
    run_op("rem ovf",     INST_REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65);
    run_op("divw ovf",    INST_DIVW, 64'hAAAA_AAAA_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 65);
    run_op("divuw",       INST_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 65);
    run_op("remuw",       INST_REMUW, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'd1, 65);
    run_op("divu max/1",  INST_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("remu 100/7",  INST_REMU, 64'd100, 64'd7, 64'd2, 65);

    // Non-divide opcode is ignored.
    @(negedge clk);
    div_start   = 1'b1;
    inst_opcode = 9'h000;
    div_op1     = 64'd100;
    div_op2     = 64'd7;
    nfin = 0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("bad opc busy", 64'(div_busy), 64'd0);
        div_start = 1'b0;
      end
      if (div_finish) nfin++;
    end
    check("bad opc finish", 64'(nfin), 64'd0);
    check("bad opc result", div_result, 64'd2);

    // Flush wins over start in the same cycle.
    @(negedge clk);
    div_start   = 1'b1;
    div_flush   = 1'b1;
    inst_opcode = INST_DIVU;
    @(negedge clk);
    div_start = 1'b0;
    div_flush = 1'b0;
    check("flush>start busy", 64'(div_busy), 64'd0);
    @(negedge clk);
    check("flush>start state", 64'(div_busy), 64'd0);

    // Flush in cycle 30, restart in cycle 32.
    @(negedge clk);
    div_start   = 1'b1;
    inst_opcode = INST_DIVU;
    div_op1     = 64'd100;
    div_op2     = 64'd7;
    nfin = 0;
    lat  = -1;
    for (int c = 1; c <= 140 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1 || c == 33) div_start = 1'b0;
      if (c < 32 && div_finish) nfin++;
      if (c == 30) begin
        check("flush busy c30", 64'(div_busy), 64'd1);
        div_flush = 1'b1;
      end
      if (c == 31) begin
        check("flush busy c31", 64'(div_busy), 64'd0);
        check("flush result", div_result, 64'd2);
        div_flush = 1'b0;
      end
      if (c == 32) div_start = 1'b1;
      if (c > 32 && div_finish) lat = c;
    end
    check("flush no finish", 64'(nfin), 64'd0);
    check("restart latency", 64'(lat), 64'd97);
    check("restart result", div_result, 64'd14);

    // Start held through busy: exactly one finish.
    @(negedge clk);
    @(negedge clk);
    div_start   = 1'b1;
    inst_opcode = INST_DIVU;
    div_op1     = 64'd100;
    div_op2     = 64'd7;
    nfin = 0;
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      if (c == 65) div_start = 1'b0;
      if (div_finish) nfin++;
    end
    check("held start finishes", 64'(nfin), 64'd1);
    check("held start result", div_result, 64'd14);

    // Reset mid-CALC clears outputs, no finish afterwards.
    @(negedge clk);
    div_start   = 1'b1;
    inst_opcode = INST_DIV;
    div_op1     = 64'd20;
    div_op2     = 64'd3;
    @(negedge clk);
    div_start = 1'b0;
    repeat (19) @(negedge clk);
    check("pre-reset busy", 64'(div_busy), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid reset busy", 64'(div_busy), 64'd0);
    check("mid reset finish", 64'(div_finish), 64'd0);
    check("mid reset result", div_result, 64'd0);
    rst  = 1'b1;
    nfin = 0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (div_finish) nfin++;
    end
    check("post reset no finish", 64'(nfin), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
